// File: rtl/hdmi_timing_ctrl.sv
// hdmi_timing_ctrl: parameterised video timing generator (hsync/vsync/de,
// pixel coordinates, line/frame strobes) running from a single pixel clock.
// Optional heartbeat LED on LED2 is built only when HDMI_TIMING_LED_EN is defined.
module hdmi_timing_ctrl #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned CW         = 12
`ifdef HDMI_TIMING_LED_EN
    ,
    parameter int unsigned LED_FRAMES = 30
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank
`ifdef HDMI_TIMING_LED_EN
    ,
    output logic          LED2
`endif
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] x_nxt, y_nxt;
    logic          hsync_nxt, vsync_nxt, de_nxt;
    logic          line_start_nxt, frame_start_nxt, vblank_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, next position and decodes of the position shown next cycle
    always_comb begin
        state_nxt       = state;
        x_nxt           = '0;
        y_nxt           = '0;
        hsync_nxt       = ~HS_POL;
        vsync_nxt       = ~VS_POL;
        de_nxt          = 1'b0;
        line_start_nxt  = 1'b0;
        frame_start_nxt = 1'b0;
        vblank_nxt      = 1'b0;

        case (state)
            IDLE:    if (en)  state_nxt = RUN;
            RUN:     if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == RUN) begin
            // Entering RUN always starts from (0,0); otherwise advance raster
            if (state == RUN) begin
                if (x == CW'(H_TOTAL - 1)) begin
                    x_nxt = '0;
                    y_nxt = (y == CW'(V_TOTAL - 1)) ? '0 : y + CW'(1);
                end else begin
                    x_nxt = x + CW'(1);
                    y_nxt = y;
                end
            end
            hsync_nxt       = ((x_nxt >= CW'(HS_START)) && (x_nxt < CW'(HS_END)))
                              ? HS_POL : ~HS_POL;
            vsync_nxt       = ((y_nxt >= CW'(VS_START)) && (y_nxt < CW'(VS_END)))
                              ? VS_POL : ~VS_POL;
            de_nxt          = (x_nxt < CW'(H_ACTIVE)) && (y_nxt < CW'(V_ACTIVE));
            line_start_nxt  = (x_nxt == '0);
            frame_start_nxt = (x_nxt == '0) && (y_nxt == '0);
            vblank_nxt      = (y_nxt >= CW'(V_ACTIVE));
        end
    end

    // Registered, mutually aligned outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
        end else begin
            x           <= x_nxt;
            y           <= y_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            de          <= de_nxt;
            line_start  <= line_start_nxt;
            frame_start <= frame_start_nxt;
            vblank      <= vblank_nxt;
        end
    end

`ifdef HDMI_TIMING_LED_EN
    localparam int unsigned LW = (LED_FRAMES < 2) ? 1 : $clog2(LED_FRAMES);

    logic [LW-1:0] led_cnt, led_cnt_nxt;
    logic          led_nxt;

    // Heartbeat: toggle on the frame_start that completes LED_FRAMES frames
    always_comb begin
        led_cnt_nxt = '0;
        led_nxt     = 1'b0;
        if (state_nxt == RUN) begin
            led_cnt_nxt = led_cnt;
            led_nxt     = LED2;
            if (frame_start_nxt) begin
                if (led_cnt == LW'(LED_FRAMES - 1)) begin
                    led_cnt_nxt = '0;
                    led_nxt     = ~LED2;
                end else begin
                    led_cnt_nxt = led_cnt + LW'(1);
                end
            end
        end
    end

    // Heartbeat registers, cleared on reset and in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_cnt <= '0;
            LED2    <= 1'b0;
        end else begin
            led_cnt <= led_cnt_nxt;
            LED2    <= led_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Self-checking bench for hdmi_timing_ctrl: small-geometry table vectors,
// enable/reset corner sequences, and one line of the default 640x480 timing.
`timescale 1ns/1ps
module tb_hdmi_timing_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic en_d;

    // Small geometry: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6)
    logic       s_hs, s_vs, s_de, s_ls, s_fs, s_vb;
    logic [3:0] s_x, s_y;
    // Default geometry
    logic        d_hs, d_vs, d_de, d_ls, d_fs, d_vb;
    logic [11:0] d_x, d_y;
`ifdef HDMI_TIMING_LED_EN
    logic s_led, d_led;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hdmi_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(4)
`ifdef HDMI_TIMING_LED_EN
        , .LED_FRAMES(2)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hsync(s_hs), .vsync(s_vs), .de(s_de), .x(s_x), .y(s_y),
        .line_start(s_ls), .frame_start(s_fs), .vblank(s_vb)
`ifdef HDMI_TIMING_LED_EN
        , .LED2(s_led)
`endif
    );

    hdmi_timing_ctrl dut_def (
        .clk(clk), .rst_n(rst_n), .en(en_d),
        .hsync(d_hs), .vsync(d_vs), .de(d_de), .x(d_x), .y(d_y),
        .line_start(d_ls), .frame_start(d_fs), .vblank(d_vb)
`ifdef HDMI_TIMING_LED_EN
        , .LED2(d_led)
`endif
    );

    typedef struct {
        int         cyc;
        logic [3:0] x;
        logic [3:0] y;
        logic [5:0] flags; // {hsync, vsync, de, line_start, frame_start, vblank}
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] s_flags();
        return {s_hs, s_vs, s_de, s_ls, s_fs, s_vb};
    endfunction

    task automatic chk_small(input string name, input logic [3:0] ex, input logic [3:0] ey,
                             input logic [5:0] ef);
        chk({name, "_x"}, int'(s_x), int'(ex));
        chk({name, "_y"}, int'(s_y), int'(ey));
        chk({name, "_flags"}, int'(s_flags()), int'(ef));
    endtask

    task automatic wait_pos(input string name, input logic [3:0] wx, input logic [3:0] wy);
        int n;
        n = 0;
        while (!(s_x == wx && s_y == wy) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout waiting for position actual=(%0d,%0d) required=(%0d,%0d)",
                     name, s_x, s_y, wx, wy);
        end
    endtask

    initial begin
        int idx;
        int de_cnt, hs_cnt, vs_cnt, ls_cnt, fs_cnt, vb_cnt;
        int fs_second;
        int dhs_cnt, dhs_first, dde_cnt;
`ifdef HDMI_TIMING_LED_EN
        int led_bad;
`endif

        //             cyc  x  y   {hs,vs,de,ls,fs,vb}
        vecs.push_back('{0,  0, 0, 6'b111110});
        vecs.push_back('{3,  3, 0, 6'b111000});
        vecs.push_back('{4,  4, 0, 6'b110000});
        vecs.push_back('{5,  5, 0, 6'b010000});
        vecs.push_back('{6,  6, 0, 6'b010000});
        vecs.push_back('{7,  7, 0, 6'b110000});
        vecs.push_back('{8,  0, 1, 6'b111100});
        vecs.push_back('{21, 5, 2, 6'b010000});
        vecs.push_back('{24, 0, 3, 6'b110101});
        vecs.push_back('{32, 0, 4, 6'b100101});
        vecs.push_back('{37, 5, 4, 6'b000001});
        vecs.push_back('{39, 7, 4, 6'b100001});
        vecs.push_back('{40, 0, 5, 6'b110101});
        vecs.push_back('{47, 7, 5, 6'b110001});
        vecs.push_back('{48, 0, 0, 6'b111110});
        vecs.push_back('{95, 7, 5, 6'b110001});

        rst_n = 1'b0;
        en    = 1'b1;
        en_d  = 1'b0;
        #12;
        // Reset state while rst_n held low
        chk_small("reset", 4'd0, 4'd0, 6'b110000);
        chk("reset_def_hs", int'(d_hs), 1);
        #10 rst_n = 1'b1; // released mid-cycle at t=22, next edge at t=25

        // Table-driven pass over two and a half frames
        idx = 0;
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; ls_cnt = 0; fs_cnt = 0; vb_cnt = 0;
        fs_second = -1;
`ifdef HDMI_TIMING_LED_EN
        led_bad = 0;
`endif
        for (int n = 0; n < 120; n++) begin
            step();
            if (idx < vecs.size() && vecs[idx].cyc == n) begin
                chk_small($sformatf("vec%0d", n), vecs[idx].x, vecs[idx].y, vecs[idx].flags);
                idx++;
            end
            if (n < 48) begin
                de_cnt += int'(s_de);
                hs_cnt += int'(!s_hs);
                vs_cnt += int'(!s_vs);
                ls_cnt += int'(s_ls);
                fs_cnt += int'(s_fs);
                vb_cnt += int'(s_vb);
            end else if (s_fs && fs_second < 0) begin
                fs_second = n;
            end
`ifdef HDMI_TIMING_LED_EN
            if (s_led != (n >= 48)) led_bad++;
`endif
        end
        chk("vec_all_applied", idx, vecs.size());
        chk("frame_de_count", de_cnt, 12);
        chk("frame_hsync_count", hs_cnt, 12);
        chk("frame_vsync_count", vs_cnt, 8);
        chk("frame_line_starts", ls_cnt, 6);
        chk("frame_frame_starts", fs_cnt, 1);
        chk("frame_vblank_count", vb_cnt, 24);
        chk("frame_period", fs_second, 48);
`ifdef HDMI_TIMING_LED_EN
        chk("led_toggle", led_bad, 0);
`endif

        // en dropped at (2,1): synchronous return to reset values
        wait_pos("wait_en_drop", 4'd2, 4'd1);
        chk_small("at_drop", 4'd2, 4'd1, 6'b111000);
        en = 1'b0;
        step();
        chk_small("en_drop", 4'd0, 4'd0, 6'b110000);
        step();
        chk_small("idle_hold", 4'd0, 4'd0, 6'b110000);
        en = 1'b1;
        step();
        chk_small("re_enable", 4'd0, 4'd0, 6'b111110);
        step();
        chk_small("re_enable_next", 4'd1, 4'd0, 6'b111000);

        // Asynchronous reset pulse while hsync is active at x=6
        wait_pos("wait_x6", 4'd6, 4'd0);
        chk("pre_reset_hsync", int'(s_hs), 0);
        #2 rst_n = 1'b0;
        #1;
        chk_small("async_reset", 4'd0, 4'd0, 6'b110000);
        #2 rst_n = 1'b1;
        step();
        chk_small("after_reset", 4'd0, 4'd0, 6'b111110);
        step();
        chk_small("after_reset_next", 4'd1, 4'd0, 6'b111000);

        // Default 640x480 timing over the first line
        en_d = 1'b1;
        step();
        chk("def_first_x", int'(d_x), 0);
        chk("def_first_flags", int'({d_hs, d_vs, d_de, d_ls, d_fs, d_vb}), int'(6'b111110));
        dhs_cnt = 0; dhs_first = -1; dde_cnt = 0;
        for (int n = 0; n < 800; n++) begin
            if (!d_hs) begin
                dhs_cnt++;
                if (dhs_first < 0) dhs_first = int'(d_x);
            end
            dde_cnt += int'(d_de);
            step();
        end
        chk("def_hsync_width", dhs_cnt, 96);
        chk("def_hsync_start", dhs_first, 656);
        chk("def_line_de", dde_cnt, 640);
        chk("def_wrap_x", int'(d_x), 0);
        chk("def_wrap_y", int'(d_y), 1);
        chk("def_line2_flags", int'({d_hs, d_vs, d_de, d_ls, d_fs, d_vb}), int'(6'b111100));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
